foc_aim_sequencer: RTL
======================

# foc_aim_sequencer

Setpoint sequencer for the FOC current loop. It produces the registered d/q target currents `id_aim`/`iq_aim` that feed `foc_top`, updating them once per control period on the `en_idq` strobe. Three modes are supported: off (ramp to zero), track a programmed target, and alternate a ±amplitude square wave on the q-axis. Every change is slew-limited and magnitude-clamped. Configuration comes from the AXI-lite register bank in the motor-control top.

## Interface
- `MAX_AIM`, default 16'sd4095: symmetric magnitude clamp applied to every target (positive, ≤ 32767).
- `CNT_W`, default 16: width of the alternate-period counter.
- `clk` input 1: the single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en_idq` input 1: one-cycle strobe, once per control period from `foc_top`.
- `stop` input 1: level; while high, forces both aims to 0 immediately.
- `cfg_mode` input 2: 0 = OFF, 1 = TRACK, 2 = ALT, 3 = reserved (behaves as OFF).
- `cfg_id_target` input 16 signed: d-axis target in TRACK and ALT.
- `cfg_iq_target` input 16 signed: q-axis target in TRACK.
- `cfg_alt_amp` input 16 signed: q-axis amplitude in ALT.
- `cfg_alt_period` input CNT_W unsigned: control periods per ALT half-cycle; 0 treated as 1.
- `cfg_step` input 16 unsigned: maximum change of each aim per control period; 0 = unlimited.
- `id_aim` output 16 signed: d-axis target to `foc_top`.
- `iq_aim` output 16 signed: q-axis target to `foc_top`.
- `aim_vld` output 1: one-cycle pulse when the aims have been updated.
- `settled` output 1: both aims equal their effective targets.
- `alt_phase` output 1: ALT half-cycle, 0 = +amp, 1 = −amp.

## Operation
- **States:** S_OFF, S_TRACK, S_ALT. Transitions happen only on an `en_idq` cycle, selected by `cfg_mode` (3 → S_OFF).
- **Config sampling:** all cfg inputs are sampled only on the `en_idq` cycle; values between strobes are ignored.
- **Effective targets (T_d, T_q)**, determined by the next state:
  - S_OFF: 0 / 0.
  - S_TRACK: `cfg_id_target` / `cfg_iq_target`.
  - S_ALT: `cfg_id_target` / (+`cfg_alt_amp` if phase is 0, else −`cfg_alt_amp`). Negate in 17 bits.
  - Every target is then clamped to [−MAX_AIM, +MAX_AIM].
- **Slew:** for each axis, diff = T − aim, computed in 17 bits.
  - If `cfg_step` ≠ 0, diff is clamped to [−step, +step].
  - aim ← aim + diff.
  - Result is never outside ±MAX_AIM and never overshoots T.
- **ALT counter (cnt, CNT_W bits) and phase:**
  - Entering S_ALT from another state: phase and cnt are taken as 0 for this strobe.
  - On each strobe in S_ALT, the target uses the current phase. Then n = cnt + 1.
  - If n ≥ max(`cfg_alt_period`, 1): cnt ← 0 and phase toggles. Otherwise cnt ← n.
  - Leaving S_ALT clears cnt and phase.
- **stop:**
  - On any cycle `stop` is high: aims ← 0, state ← S_OFF, cnt and phase ← 0.
  - No slew limit applies.
  - `aim_vld` pulses only if `en_idq` is also high.
  - `stop` has priority over a simultaneous `en_idq`.
- **settled:** combinational compare of the aims against the last-computed effective targets, held in registers. Reset value is 1.

## Timing
- Reset values:
  - `id_aim` = `iq_aim` = 0.
  - `aim_vld` = 0.
  - `settled` = 1.
  - `alt_phase` = 0.
  - state = S_OFF, cnt = 0.
- Reset asserted mid-ramp or mid-ALT returns everything to the reset values on the next edge.
- Latency: `en_idq` high in cycle N → new aims, `aim_vld` = 1, and updated `alt_phase` are all visible in cycle N+1.
- The aims are stable between strobes. `foc_top` may sample them at any time.
- Back-to-back `en_idq` (every cycle) must be handled: one update per strobe.
- `stop` asserted in cycle N → aims = 0 in cycle N+1. They stay 0 while `stop` is high.
- After `stop` deasserts, the next `en_idq` resumes normally from state S_OFF.

## Test plan
- **TRACK ramp:** mode 1, iq target 1000, step 300, from 0.
  - Required iq_aim over 4 strobes: 300, 600, 900, 1000.
  - `settled` = 0 until the 4th strobe, then 1.
  - `aim_vld` is exactly one cycle per strobe.
- **OFF ramp-down:** from iq_aim 1000, switch to mode 0 with step 300.
  - Required iq_aim: 700, 400, 100, 0.
  - Mode 3 gives an identical result.
- **ALT:** amp 200, period 3, step 0, id target 0.
  - Required iq_aim over 7 strobes: +200, +200, +200, −200, −200, −200, +200.
  - `alt_phase` follows; period 0 toggles on every strobe.
- **Clamp:**
  - TRACK iq target 20000, step 0 → 4095.
  - Target −32768 → −4095.
  - ALT amp −32768 in phase 1 → +4095 with no overflow.
- **stop priority:** during a ramp at 600, assert `stop` together with `en_idq`.
  - Required next cycle: aims 0, state S_OFF, `aim_vld` = 1.
  - Aims hold 0 with `stop` high through 3 more strobes.
- **Reset mid-ALT:** assert `rst` for 1 cycle while in the −phase.
  - Required: all outputs at reset values.
  - The next strobe with mode 2 restarts at +amp with cnt = 1.

Source files
------------

// File: rtl/foc_aim_sequencer.sv
// -----------------------------------------------------------------------------
// foc_aim_sequencer
//
// Setpoint sequencer for the FOC current loop. Produces registered d/q target
// currents that change once per control period on the en_idq strobe. Three
// modes: OFF (ramp both aims to zero), TRACK (ramp to programmed targets) and
// ALT (q-axis square wave of +/- amplitude). Every change is slew-limited by
// cfg_step and every target is clamped to +/- MAX_AIM.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous, active-high reset
//   en_idq         : one-cycle strobe per control period
//   stop           : level; forces both aims to 0 on every cycle it is high
//   cfg_mode       : 0 OFF, 1 TRACK, 2 ALT, 3 reserved (acts as OFF)
//   cfg_id_target  : d-axis target (TRACK and ALT)
//   cfg_iq_target  : q-axis target (TRACK)
//   cfg_alt_amp    : q-axis amplitude (ALT)
//   cfg_alt_period : strobes per ALT half-cycle (0 acts as 1)
//   cfg_step       : max change per strobe per axis (0 = unlimited)
//   id_aim/iq_aim  : registered d/q targets
//   aim_vld        : one-cycle pulse after an update strobe
//   settled        : both aims equal their last effective targets
//   alt_phase      : ALT half-cycle, 0 = +amp, 1 = -amp
// -----------------------------------------------------------------------------
module foc_aim_sequencer #(
    parameter logic signed [15:0] MAX_AIM = 16'sd4095,
    parameter int                 CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_idq,
    input  logic                stop,
    input  logic [1:0]          cfg_mode,
    input  logic signed [15:0]  cfg_id_target,
    input  logic signed [15:0]  cfg_iq_target,
    input  logic signed [15:0]  cfg_alt_amp,
    input  logic [CNT_W-1:0]    cfg_alt_period,
    input  logic [15:0]         cfg_step,
    output logic signed [15:0]  id_aim,
    output logic signed [15:0]  iq_aim,
    output logic                aim_vld,
    output logic                settled,
    output logic                alt_phase
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_TRACK = 2'd1,
        S_ALT   = 2'd2
    } state_e;

    localparam logic signed [16:0] MAX17 = {MAX_AIM[15], MAX_AIM};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic signed [15:0]  id_aim_q, id_aim_d;
    logic signed [15:0]  iq_aim_q, iq_aim_d;
    logic signed [15:0]  td_q, td_d;      // last effective d target
    logic signed [15:0]  tq_q, tq_d;      // last effective q target
    logic                vld_q;

    // Clamp a 17-bit value into [-MAX_AIM, +MAX_AIM].
    function automatic logic signed [15:0] clamp_aim(input logic signed [16:0] v);
        logic signed [15:0] r;
        if (v > MAX17)       r = MAX_AIM;
        else if (v < -MAX17) r = -MAX_AIM;
        else                 r = v[15:0];
        return r;
    endfunction

    // Move aim toward tgt by at most step (step 0 = jump). Widened to 18 bits
    // so diff and the step bound never wrap; the sum always lands between aim
    // and tgt, so it fits back into 16 bits.
    function automatic logic signed [15:0] slew(input logic signed [15:0] aim,
                                                input logic signed [15:0] tgt,
                                                input logic [15:0]        step);
        logic signed [17:0] diff;
        logic signed [17:0] stp;
        logic signed [17:0] sum;
        diff = {{2{tgt[15]}}, tgt} - {{2{aim[15]}}, aim};
        stp  = {2'b00, step};
        if (step != 16'd0) begin
            if (diff > stp)       diff = stp;
            else if (diff < -stp) diff = -stp;
        end
        sum = {{2{aim[15]}}, aim} + diff;
        return sum[15:0];
    endfunction

    state_e              mode_state;
    logic                cur_phase;
    logic [CNT_W-1:0]    cur_cnt;
    logic [CNT_W:0]      cnt_next;
    logic [CNT_W-1:0]    period_eff;
    logic signed [16:0]  amp17;
    logic signed [16:0]  tq_raw;
    logic signed [15:0]  t_d, t_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        id_aim_d = id_aim_q;
        iq_aim_d = iq_aim_q;
        td_d     = td_q;
        tq_d     = tq_q;

        case (cfg_mode)
            2'd1:    mode_state = S_TRACK;
            2'd2:    mode_state = S_ALT;
            default: mode_state = S_OFF;
        endcase

        // Entering ALT starts a fresh half-cycle at +amp.
        cur_phase  = (state_q == S_ALT) ? phase_q : 1'b0;
        cur_cnt    = (state_q == S_ALT) ? cnt_q   : '0;
        cnt_next   = {1'b0, cur_cnt} + 1'b1;
        period_eff = (cfg_alt_period == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cfg_alt_period;

        amp17  = {cfg_alt_amp[15], cfg_alt_amp};
        tq_raw = cur_phase ? -amp17 : amp17;

        t_d = '0;
        t_q = '0;
        case (mode_state)
            S_TRACK: begin
                t_d = clamp_aim({cfg_id_target[15], cfg_id_target});
                t_q = clamp_aim({cfg_iq_target[15], cfg_iq_target});
            end
            S_ALT: begin
                t_d = clamp_aim({cfg_id_target[15], cfg_id_target});
                t_q = clamp_aim(tq_raw);
            end
            default: ;
        endcase

        if (stop) begin
            // Immediate zero, no slew; stop outranks a coincident strobe.
            state_d  = S_OFF;
            cnt_d    = '0;
            phase_d  = 1'b0;
            id_aim_d = '0;
            iq_aim_d = '0;
            td_d     = '0;
            tq_d     = '0;
        end else if (en_idq) begin
            state_d  = mode_state;
            td_d     = t_d;
            tq_d     = t_q;
            id_aim_d = slew(id_aim_q, t_d, cfg_step);
            iq_aim_d = slew(iq_aim_q, t_q, cfg_step);
            if (mode_state == S_ALT) begin
                if (cnt_next >= {1'b0, period_eff}) begin
                    cnt_d   = '0;
                    phase_d = ~cur_phase;
                end else begin
                    cnt_d   = cnt_next[CNT_W-1:0];
                    phase_d = cur_phase;
                end
            end else begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            id_aim_q <= '0;
            iq_aim_q <= '0;
            td_q     <= '0;
            tq_q     <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            id_aim_q <= id_aim_d;
            iq_aim_q <= iq_aim_d;
            td_q     <= td_d;
            tq_q     <= tq_d;
            vld_q    <= en_idq;
        end
    end

    assign id_aim    = id_aim_q;
    assign iq_aim    = iq_aim_q;
    assign aim_vld   = vld_q;
    assign alt_phase = phase_q;
    assign settled   = (id_aim_q == td_q) && (iq_aim_q == tq_q);

endmodule
